// File: rtl/iq_power_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iq_power_pkg : shared state encoding and width helpers  (rev 1.0)    |
// +----------------------------------------------------------------------+
package iq_power_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ_I = 2'd1,
        SQ_Q = 2'd2,
        DONE = 2'd3
    } iq_power_state_t;

    function automatic int sample_width(input int n);
        return n / 2;
    endfunction

    // A 1-bit counter is still needed when W collapses to 2.
    function automatic int count_width(input int n);
        return (n / 2 > 2) ? $clog2(n / 2) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/abs_signed.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | abs_signed : W-bit signed to W-bit unsigned magnitude    (rev 1.0)   |
// +----------------------------------------------------------------------+
module abs_signed #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] x,
    output logic        [W-1:0] y
);

    logic [W-1:0] x_bits;

    // The most negative input maps to 2^(W-1), which fits unsigned W bits.
    always_comb begin
        x_bits = $unsigned(x);
        y      = x_bits[W-1] ? (~x_bits + {{(W-1){1'b0}}, 1'b1}) : x_bits;
    end

endmodule
`default_nettype wire

// File: rtl/iq_power_sequential.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iq_power_sequential : bit-serial I^2 + Q^2 with valid/ready (rev 1.0)|
// +----------------------------------------------------------------------+
module iq_power_sequential
    import iq_power_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [N/2-1:0]   i_in,
    input  logic signed [N/2-1:0]   q_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N-1:0]            pwr,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int W     = sample_width(N);
    localparam int CNT_W = count_width(N);

    iq_power_state_t state, state_next;

    logic [W-1:0]     abs_i;
    logic [W-1:0]     abs_q;
    logic [W-1:0]     b_hold;
    logic [N-1:0]     acc;
    logic [N-1:0]     m;
    logic [W-1:0]     s;
    logic [CNT_W-1:0] cnt;
    logic             capture;
    logic             stepping;
    logic             last_step;

    abs_signed #(.W(W)) u_abs_i (.x(i_in), .y(abs_i));
    abs_signed #(.W(W)) u_abs_q (.x(q_in), .y(abs_q));

    assign capture   = (state == IDLE) && in_valid;
    assign stepping  = (state == SQ_I) || (state == SQ_Q);
    assign last_step = (cnt == CNT_W'(W - 1));
    assign pwr       = acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = reset;
                if (in_valid) state_next = SQ_I;
            end
            SQ_I: if (last_step) state_next = SQ_Q;
            SQ_Q: if (last_step) state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift-add datapath; the last SQ_I step also reloads the Q operand.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            m      <= '0;
            s      <= '0;
            cnt    <= '0;
            b_hold <= '0;
        end else if (capture) begin
            acc    <= '0;
            cnt    <= '0;
            m      <= {{(N-W){1'b0}}, abs_i};
            s      <= abs_i;
            b_hold <= abs_q;
        end else if (stepping) begin
            if (s[0]) acc <= acc + m;
            if ((state == SQ_I) && last_step) begin
                m   <= {{(N-W){1'b0}}, b_hold};
                s   <= b_hold;
                cnt <= '0;
            end else begin
                m   <= m << 1;
                s   <= s >> 1;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/iq_power_sequential.md
# iq_power_sequential

Sequential sum-of-squares stage that computes P = I² + Q² from one signed I/Q sample pair using a shift-add multiplier, one bit per clock. It sits directly upstream of the sequential square-root block. Its N-bit unsigned result is that block's radicand, so sqrt(P) gives the sample magnitude |I + jQ|. Input and output use valid/ready handshakes, and the block processes one sample at a time.

## Interface
- N, default 16: output width. Must be even and ≥ 4. Input width is W = N/2.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. Clears all state immediately when low.
- i_in  in  N/2  signed two's-complement I sample.
- q_in  in  N/2  signed two's-complement Q sample.
- in_valid  in  1  i_in/q_in are valid this cycle.
- in_ready  out  1  block can accept a sample. High only in IDLE.
- pwr  out  N  unsigned I² + Q². Valid while out_valid is high.
- out_valid  out  1  pwr is valid. Held until accepted.
- out_ready  in  1  downstream accepts pwr this cycle.

## Operation
- States: IDLE, SQ_I, SQ_Q, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, capture a = |i_in| and b = |q_in|, each W-bit unsigned. |−2^(W−1)| = 2^(W−1), with no saturation.
  - On capture: acc ← 0, cnt ← 0, multiplicand m ← a zero-extended to N bits, multiplier bits s ← a. Go to SQ_I.
- SQ_I, one step per cycle:
  - If s[0], acc ← acc + m.
  - m ← m << 1, s ← s >> 1, cnt ← cnt + 1.
  - On the step where cnt == W−1: reload m ← b zero-extended, s ← b, cnt ← 0. Go to SQ_Q.
- SQ_Q:
  - Same step as SQ_I, without clearing acc.
  - On cnt == W−1, go to DONE.
- DONE:
  - out_valid = 1, pwr = acc.
  - If out_ready, go to IDLE. Otherwise hold state and pwr unchanged.
- Widths:
  - acc, m and pwr are N bits. The maximum result is 2·2^(2W−2) = 2^(N−1), so no overflow occurs and no carry-out bit is needed.
  - cnt is $clog2(W) bits.
- in_valid while not in IDLE is ignored; in_ready is low, so no capture occurs.
- An unused state encoding goes to IDLE.

## Timing
- Reset values: in_ready = 0 while reset is low, then 1 in IDLE. out_valid = 0, pwr = 0, state = IDLE, acc = m = s = cnt = 0.
- Latency: let E0 be the edge where in_valid && in_ready is sampled. out_valid rises after edge E0 + 2W, i.e. 16 cycles for N = 16.
- Handshake rules:
  - A transfer occurs on any edge where valid && ready are both high.
  - pwr must stay stable while out_valid = 1 and out_ready = 0.
- Throughput: one sample per 2W + 2 cycles when out_ready is held high. There is one IDLE bubble after DONE; in_ready is never combinationally tied to out_ready.
- Simultaneous events: in DONE with out_ready = 1 and in_valid = 1, the new sample is not captured until the following IDLE cycle.
- Reset mid-operation: asynchronous return to IDLE. The partial result is discarded and out_valid drops immediately.

## Structure
- Shared package iq_power_pkg:
  - iq_power_state_t enum (logic [1:0]: IDLE = 0, SQ_I = 1, SQ_Q = 2, DONE = 3).
  - Helper localparam functions for W and the counter width.
- One sub-module: abs_signed, a combinational W-bit signed → W-bit unsigned absolute value. It is instantiated twice, for I and Q.
- Control FSM and datapath (acc, m, s, cnt) are in the top module, in separate always_ff blocks, both with asynchronous active-low reset.

## Test plan
- N = 16, I = 3, Q = 4, out_ready held high → pwr = 25 with out_valid one cycle, exactly 16 edges after acceptance. in_ready is low throughout.
- I = −128, Q = −128 → pwr = 32768 (0x8000). I = 127, Q = −128 → pwr = 32513. I = 0, Q = 0 → pwr = 0.
- Backpressure: result for I = −5, Q = 12 (169) with out_ready low for 5 cycles → out_valid and pwr = 169 held stable, and in_ready stays 0 until the cycle after out_ready is accepted.
- in_valid pulsed mid-computation with I = 1, Q = 1 → ignored; the first result is unaffected and no second out_valid appears.
- Reset asserted asynchronously mid-SQ_Q → out_valid = 0, in_ready = 0 during reset, IDLE after release. A following I = 6, Q = 8 gives pwr = 100.
- Random I/Q back-to-back stream (1000 samples), with the result fed to the square-root stage → pwr matches the reference I² + Q² and the square root equals floor(sqrt(I² + Q²)).
